// File: rtl/bluetooth_rx.sv
// bluetooth_rx: 8N1 serial receiver for the Bluetooth module link.
// It deserialises bytes from the module's TX line and packs consecutive bytes,
// little-endian, into N_BITS-wide words for the fetal ECG pipeline.
// If a word is left half-finished, the partial bytes are dropped after a
// quiet period of BYTE_TIMEOUT bit times.
module bluetooth_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_BITS       = 32,
    parameter int BYTE_TIMEOUT = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_rx_serial,
    output logic [7:0]        out_rx_byte,
    output logic              out_rx_byte_valid,
    output logic [N_BITS-1:0] out_rx_data,
    output logic              out_rx_valid,
    output logic              out_rx_active,
    output logic              out_frame_err,
    output logic              out_timeout
);

    localparam int NB       = N_BITS / 8;
    localparam int BCW      = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int TO_LIMIT = BYTE_TIMEOUT * CLKS_PER_BIT;
    localparam int TW       = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
    localparam int HALF     = (CLKS_PER_BIT - 1) / 2;

    if ((N_BITS % 8) != 0) begin : g_bad_width
        $error("bluetooth_rx: N_BITS must be a multiple of 8");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("bluetooth_rx: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic [CW-1:0]     r_clk_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [BCW-1:0]    r_byte_cnt;
    logic [TW-1:0]     r_to_cnt;
    logic              r_wait_high;
    logic [N_BITS-1:0] r_word;
    logic [7:0]        r_byte;
    logic              r_byte_valid;
    logic [N_BITS-1:0] r_data;
    logic              r_rx_valid;
    logic              r_active;
    logic              r_frame_err;
    logic              r_timeout;
    logic [N_BITS-1:0] w_word_next;

    assign out_rx_byte       = r_byte;
    assign out_rx_byte_valid = r_byte_valid;
    assign out_rx_data       = r_data;
    assign out_rx_valid      = r_rx_valid;
    assign out_rx_active     = r_active;
    assign out_frame_err     = r_frame_err;
    assign out_timeout       = r_timeout;

    // Partial word with the byte just shifted in placed into its lane
    always_comb begin
        w_word_next = r_word;
        w_word_next[r_byte_cnt * 8 +: 8] = r_shift;
    end

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= in_rx_serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receive FSM, word assembly, partial-word timeout and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_cnt   <= '0;
            r_to_cnt     <= '0;
            r_wait_high  <= 1'b0;
            r_word       <= '0;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_data       <= '0;
            r_rx_valid   <= 1'b0;
            r_active     <= 1'b0;
            r_frame_err  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s && !r_wait_high) begin
                        // A start edge takes priority over an expiring timeout
                        r_state   <= ST_START;
                        r_active  <= 1'b1;
                        r_clk_cnt <= '0;
                        r_to_cnt  <= '0;
                    end else begin
                        if (r_wait_high && r_rx_s) begin
                            r_wait_high <= 1'b0;
                        end
                        if (r_byte_cnt != BCW'(0)) begin
                            if (r_to_cnt == TW'(TO_LIMIT - 1)) begin
                                r_to_cnt   <= '0;
                                r_byte_cnt <= '0;
                                r_timeout  <= 1'b1;
                            end else begin
                                r_to_cnt <= r_to_cnt + TW'(1);
                            end
                        end else begin
                            r_to_cnt <= '0;
                        end
                    end
                end
                ST_START: begin
                    if (r_clk_cnt == CW'(HALF)) begin
                        r_clk_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            // Glitch shorter than half a bit: drop silently
                            r_state  <= ST_IDLE;
                            r_active <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        // Return to IDLE mid stop bit so back-to-back frames are caught
                        r_clk_cnt <= '0;
                        r_state   <= ST_IDLE;
                        r_active  <= 1'b0;
                        if (r_rx_s) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                            r_word       <= w_word_next;
                            if (r_byte_cnt == BCW'(NB - 1)) begin
                                r_data     <= w_word_next;
                                r_rx_valid <= 1'b1;
                                r_byte_cnt <= '0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + BCW'(1);
                            end
                        end else begin
                            // Bad stop bit: drop the word and wait for the line to recover
                            r_frame_err <= 1'b1;
                            r_byte_cnt  <= '0;
                            r_wait_high <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bluetooth_rx.sv
// Directed testbench for bluetooth_rx with CLKS_PER_BIT=8, N_BITS=32, BYTE_TIMEOUT=20.
module tb_bluetooth_rx;

    localparam int CPB = 8;

    logic        clk;
    logic        rst;
    logic        in_rx_serial;
    logic [7:0]  out_rx_byte;
    logic        out_rx_byte_valid;
    logic [31:0] out_rx_data;
    logic        out_rx_valid;
    logic        out_rx_active;
    logic        out_frame_err;
    logic        out_timeout;

    int n_vec  = 0;
    int n_fail = 0;

    // Event log filled by the monitor
    int          cyc = 0;
    logic [7:0]  byte_q[$];
    int          byte_t_q[$];
    logic [31:0] word_q[$];
    int          ferr_cnt  = 0;
    int          to_cnt    = 0;
    int          to_t      = 0;
    int          coinc_err = 0;
    int          excl_err  = 0;

    bluetooth_rx #(
        .CLKS_PER_BIT (CPB),
        .N_BITS       (32),
        .BYTE_TIMEOUT (20)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_rx_serial      (in_rx_serial),
        .out_rx_byte       (out_rx_byte),
        .out_rx_byte_valid (out_rx_byte_valid),
        .out_rx_data       (out_rx_data),
        .out_rx_valid      (out_rx_valid),
        .out_rx_active     (out_rx_active),
        .out_frame_err     (out_frame_err),
        .out_timeout       (out_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output pulse, sampled away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (out_rx_byte_valid) begin
            byte_q.push_back(out_rx_byte);
            byte_t_q.push_back(cyc);
        end
        if (out_rx_valid) begin
            word_q.push_back(out_rx_data);
            if (!out_rx_byte_valid) coinc_err = coinc_err + 1;
        end
        if (out_frame_err) begin
            ferr_cnt = ferr_cnt + 1;
            if (out_rx_byte_valid) excl_err = excl_err + 1;
        end
        if (out_timeout) begin
            to_cnt = to_cnt + 1;
            to_t   = cyc;
        end
    end

    function automatic logic [7:0] byte_at(input int i);
        if (i >= 0 && i < byte_q.size()) return byte_q[i];
        return 8'hxx;
    endfunction

    function automatic logic [31:0] word_at(input int i);
        if (i >= 0 && i < word_q.size()) return word_q[i];
        return 32'hxxxxxxxx;
    endfunction

    task automatic drive_bit(input logic v);
        in_rx_serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int idle_bits);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
    endtask

    task automatic test_reset();
        logic [44:0] outs;
        rst = 1'b0;
        in_rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        outs = {out_rx_byte, out_rx_byte_valid, out_rx_data, out_rx_valid,
                out_rx_active, out_frame_err, out_timeout};
        n_vec++;
        if (outs !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_word();
        logic [7:0] tv [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        int b0 = byte_q.size();
        int w0 = word_q.size();
        for (int i = 0; i < 4; i++) send_frame(tv[i], 1'b1, 2);
        repeat (10) @(negedge clk);
        n_vec++;
        if (byte_q.size() - b0 !== 4) begin
            n_fail++;
            $display("FAIL word_byte_count got %0d want 4", byte_q.size() - b0);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (byte_at(b0 + i) !== tv[i]) begin
                n_fail++;
                $display("FAIL word_byte%0d got %h want %h", i, byte_at(b0 + i), tv[i]);
            end
        end
        n_vec++;
        if (word_q.size() - w0 !== 1) begin
            n_fail++;
            $display("FAIL word_count got %0d want 1", word_q.size() - w0);
        end
        n_vec++;
        if (word_at(w0) !== 32'h12345678) begin
            n_fail++;
            $display("FAIL word_data got %h want 12345678", word_at(w0));
        end
        n_vec++;
        if (coinc_err !== 0) begin
            n_fail++;
            $display("FAIL word_coincident got %0d lone word pulses want 0", coinc_err);
        end
    endtask

    task automatic test_glitch();
        int b0 = byte_q.size();
        int f0 = ferr_cnt;
        int t0 = to_cnt;
        logic seen_hi = 1'b0;
        logic seen_lo = 1'b0;
        in_rx_serial = 1'b0;
        repeat (2) @(negedge clk);
        in_rx_serial = 1'b1;
        for (int i = 0; i < 10 && !seen_hi; i++) begin
            if (out_rx_active) seen_hi = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (seen_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_active_rise got %b want 1", seen_hi);
        end
        for (int i = 0; i < 12 && !seen_lo; i++) begin
            if (!out_rx_active) seen_lo = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (seen_lo !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_active_fall got %b want 1", seen_lo);
        end
        repeat (40) @(negedge clk);
        n_vec++;
        if ({byte_q.size() - b0, ferr_cnt - f0, to_cnt - t0} !== {32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL glitch_no_pulse got bytes=%0d ferr=%0d to=%0d want 0 0 0",
                     byte_q.size() - b0, ferr_cnt - f0, to_cnt - t0);
        end
    endtask

    task automatic test_frame_err();
        int b0 = byte_q.size();
        int w0 = word_q.size();
        int f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0, 2);
        n_vec++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - f0);
        end
        n_vec++;
        if (byte_q.size() - b0 !== 0) begin
            n_fail++;
            $display("FAIL ferr_no_byte got %0d want 0", byte_q.size() - b0);
        end
        send_frame(8'h01, 1'b1, 1);
        send_frame(8'h02, 1'b1, 1);
        send_frame(8'h03, 1'b1, 1);
        send_frame(8'h04, 1'b1, 1);
        repeat (10) @(negedge clk);
        n_vec++;
        if (word_at(w0) !== 32'h04030201) begin
            n_fail++;
            $display("FAIL ferr_next_word got %h want 04030201", word_at(w0));
        end
        n_vec++;
        if (excl_err !== 0) begin
            n_fail++;
            $display("FAIL ferr_exclusive got %0d overlaps want 0", excl_err);
        end
    endtask

    task automatic test_timeout();
        int w0 = word_q.size();
        int t0 = to_cnt;
        int last_b;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 22);
        last_b = (byte_t_q.size() > 0) ? byte_t_q[byte_t_q.size() - 1] : 0;
        n_vec++;
        if (to_cnt - t0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_pulse got %0d want 1", to_cnt - t0);
        end
        n_vec++;
        if (to_t - last_b !== 160) begin
            n_fail++;
            $display("FAIL timeout_delay got %0d want 160", to_t - last_b);
        end
        send_frame(8'hEF, 1'b1, 1);
        send_frame(8'hBE, 1'b1, 1);
        send_frame(8'hAD, 1'b1, 1);
        send_frame(8'hDE, 1'b1, 1);
        repeat (10) @(negedge clk);
        n_vec++;
        if (word_q.size() - w0 !== 1 || word_at(w0) !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL timeout_next_word got %h (n=%0d) want deadbeef (n=1)",
                     word_at(w0), word_q.size() - w0);
        end
    endtask

    task automatic test_reset_mid();
        logic [44:0] outs;
        int w0, b0, f0, t0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        repeat (4) @(negedge clk);
        n_vec++;
        if (out_rx_active !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_active_before got %b want 1", out_rx_active);
        end
        rst = 1'b0;
        @(negedge clk);
        outs = {out_rx_byte, out_rx_byte_valid, out_rx_data, out_rx_valid,
                out_rx_active, out_frame_err, out_timeout};
        n_vec++;
        if (outs !== 45'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %h want 0", outs);
        end
        rst = 1'b1;
        in_rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        w0 = word_q.size();
        b0 = byte_q.size();
        f0 = ferr_cnt;
        t0 = to_cnt;
        send_frame(8'h0D, 1'b1, 1);
        send_frame(8'hF0, 1'b1, 1);
        send_frame(8'hFE, 1'b1, 1);
        send_frame(8'hCA, 1'b1, 1);
        repeat (10) @(negedge clk);
        n_vec++;
        if (word_q.size() - w0 !== 1 || word_at(w0) !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL midreset_word got %h (n=%0d) want cafef00d (n=1)",
                     word_at(w0), word_q.size() - w0);
        end
        n_vec++;
        if ({byte_q.size() - b0, ferr_cnt - f0, to_cnt - t0} !== {32'd4, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL midreset_pulses got bytes=%0d ferr=%0d to=%0d want 4 0 0",
                     byte_q.size() - b0, ferr_cnt - f0, to_cnt - t0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tv [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int b0 = byte_q.size();
        int f0 = ferr_cnt;
        int w0;
        in_rx_serial = 1'b0;
        repeat (3 * 10 * CPB) @(negedge clk);
        n_vec++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL break_ferr got %0d want 1", ferr_cnt - f0);
        end
        n_vec++;
        if (out_rx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL break_idle got active=%b want 0", out_rx_active);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        n_vec++;
        if (ferr_cnt - f0 !== 1 || byte_q.size() - b0 !== 0) begin
            n_fail++;
            $display("FAIL break_after got ferr=%0d bytes=%0d want 1 0",
                     ferr_cnt - f0, byte_q.size() - b0);
        end
        w0 = word_q.size();
        for (int i = 0; i < 8; i++) send_frame(tv[i], 1'b1, 0);
        repeat (10) @(negedge clk);
        n_vec++;
        if (word_q.size() - w0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 2", word_q.size() - w0);
        end
        n_vec++;
        if (word_at(w0) !== 32'h44332211) begin
            n_fail++;
            $display("FAIL b2b_word0 got %h want 44332211", word_at(w0));
        end
        n_vec++;
        if (word_at(w0 + 1) !== 32'h88776655) begin
            n_fail++;
            $display("FAIL b2b_word1 got %h want 88776655", word_at(w0 + 1));
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_glitch();
        test_frame_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
